// File: rtl/dsm_dac_pkg.sv
// rtl/dsm_dac_pkg.sv - shared sample type, reset constant and sine LUT builder for dsm_sine_dac
package dsm_dac_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] sample_t;

  // Mid-scale: the sine's zero crossing, also LUT[0].
  localparam sample_t SIN_RST = 16'h8000;

  localparam real PI = 3.14159265358979323846;

  // Entry k of an n-point table: round(32768 + 32767*sin(2*pi*k/n)).
  // Sine by Taylor series after folding the angle into [-pi, pi], so the
  // table is fixed at elaboration with plain real arithmetic only.
  function automatic sample_t lut_val(input int k, input int n);
    real x;
    real term;
    real s;
    x = 2.0 * PI * real'(k) / real'(n);
    if (x > PI) begin
      x = x - 2.0 * PI;
    end
    term = x;
    s    = x;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    return sample_t'($rtoi(32768.0 + 32767.0 * s + 0.5));
  endfunction

endpackage

// File: rtl/dsm_dac_mod.sv
// rtl/dsm_dac_mod.sv - first-order delta-sigma modulator; DSM_DAC_DIFF_OUT_EN adds dsm_out_n
module dsm_dac_mod #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         dsm_out
`ifdef DSM_DAC_DIFF_OUT_EN
  ,
  output logic         dsm_out_n
`endif
);

  logic [W-1:0] r_acc;
  logic         r_dsm;
  logic [W:0]   w_sum;

  // The carry out of the accumulator is the output bit; wrap is intentional.
  assign w_sum = {1'b0, r_acc} + {1'b0, din};

  // Accumulate and register the carry every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_dsm <= 1'b0;
    end else begin
      r_acc <= w_sum[W-1:0];
      r_dsm <= w_sum[W];
    end
  end

  assign dsm_out = r_dsm;

`ifdef DSM_DAC_DIFF_OUT_EN
  logic r_dsm_n;

  // Separate flop so the complement switches on the same edge as dsm_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsm_n <= 1'b1;
    end else begin
      r_dsm_n <= ~w_sum[W];
    end
  end

  assign dsm_out_n = r_dsm_n;
`endif

endmodule

// File: rtl/dsm_sine_dac.sv
// rtl/dsm_sine_dac.sv - sine test-tone source driving a 1-bit delta-sigma DAC; DSM_DAC_DIFF_OUT_EN adds dsm_out_n
module dsm_sine_dac #(
  parameter int DIV    = 100,
  parameter int N_PTS  = 97,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              tick,
  output logic [DATA_W-1:0] sin_out,
  output logic              dsm_out
`ifdef DSM_DAC_DIFF_OUT_EN
  ,
  output logic              dsm_out_n
`endif
);

  import dsm_dac_pkg::*;

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(N_PTS);

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_sin;
  logic              w_tick;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] w_lut [N_PTS];

  // Table contents are elaboration-time constants.
  for (genvar k = 0; k < N_PTS; k++) begin : g_lut
    localparam sample_t C_VAL = lut_val(k, N_PTS);
    assign w_lut[k] = DATA_W'(C_VAL);
  end

  assign w_tick    = (r_cnt == CNT_W'(DIV - 1));
  assign w_idx_nxt = (r_idx == IDX_W'(N_PTS - 1)) ? '0 : r_idx + 1'b1;

  // Free-running sample-rate divider; tick is the terminal-count decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Step through the table on each tick and register the new sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_sin <= DATA_W'(SIN_RST);
    end else if (w_tick) begin
      r_idx <= w_idx_nxt;
      r_sin <= w_lut[w_idx_nxt];
    end
  end

  assign tick    = w_tick;
  assign sin_out = r_sin;

  dsm_dac_mod #(
    .W (DATA_W)
  ) u_mod (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (r_sin),
    .dsm_out   (dsm_out)
`ifdef DSM_DAC_DIFF_OUT_EN
    ,
    .dsm_out_n (dsm_out_n)
`endif
  );

endmodule

// File: tb/tb_dsm_sine_dac.sv
// tb/tb_dsm_sine_dac.sv - scoreboard bench for dsm_sine_dac and dsm_dac_mod; honours DSM_DAC_DIFF_OUT_EN
`timescale 1ns/1ps
module tb_dsm_sine_dac;

  localparam int DIV = 100;
  localparam int N   = 97;
  localparam real PI = 3.14159265358979323846;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick;
  logic [15:0] sin_out;
  logic        dsm_out;
`ifdef DSM_DAC_DIFF_OUT_EN
  logic        dsm_out_n;
  logic        m_out_n;
`endif

  logic        rst_m_n = 1'b1;
  logic [15:0] din_m   = 16'h8000;
  logic        m_out;

  always #5 clk = ~clk;

  dsm_sine_dac #(.DIV(DIV), .N_PTS(N), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .sin_out   (sin_out),
    .dsm_out   (dsm_out)
`ifdef DSM_DAC_DIFF_OUT_EN
    ,
    .dsm_out_n (dsm_out_n)
`endif
  );

  dsm_dac_mod #(.W(16)) u_mod (
    .clk       (clk),
    .rst_n     (rst_m_n),
    .din       (din_m),
    .dsm_out   (m_out)
`ifdef DSM_DAC_DIFF_OUT_EN
    ,
    .dsm_out_n (m_out_n)
`endif
  );

  typedef struct {
    bit rst;
    int n;
    bit tick;
    int sin;
    bit dsm;
  } exp_t;

  exp_t   q[$];
  int     lut[N];
  longint s_acc;
  int     n_cur;
  bit     first_run = 1'b0;
  int     ones_cnt  = 0;
  int     n_chk     = 0;
  int     n_fail    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Sample held after n clock edges since reset release: one table step per DIV edges.
  function automatic int sin_at(input int n);
    return lut[(n / DIV) % N];
  endfunction

  task automatic push_reset();
    exp_t e;
    n_cur = 0;
    s_acc = 0;
    e = '{rst: 1'b1, n: 0, tick: 1'b0, sin: 32768, dsm: 1'b0};
    q.push_back(e);
  endtask

  // Output bit = change in floor(cumulative input / 65536) across one edge.
  task automatic push_step();
    exp_t   e;
    longint s_new;
    s_new = s_acc + longint'(sin_at(n_cur));
    n_cur++;
    e.rst  = 1'b0;
    e.n    = n_cur;
    e.tick = ((n_cur % DIV) == DIV - 1);
    e.sin  = sin_at(n_cur);
    e.dsm  = ((s_new >> 16) != (s_acc >> 16));
    s_acc  = s_new;
    q.push_back(e);
  endtask

  task automatic clock_cycle();
    @(posedge clk);
    #1;
    if (!rst_n) push_reset();
    else        push_step();
  endtask

  // Monitor: pop one expectation per cycle and compare against the DUT.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("tick", tick, e.tick);
      check("sin_out", sin_out, e.sin);
      check("dsm_out", dsm_out, e.dsm);
      if (!e.rst && (e.n % DIV) == 0) begin
        if (e.n / DIV == 24) check("spot_lut24", sin_out, 65531);
        if (e.n / DIV == 73) check("spot_lut73", sin_out, 5);
        if (e.n / DIV == 97) check("spot_lut0_wrap", sin_out, 32768);
      end
      if (first_run && !e.rst && e.n >= 1 && e.n <= DIV * N && dsm_out === 1'b1)
        ones_cnt++;
    end
`ifdef DSM_DAC_DIFF_OUT_EN
    check("dsm_out_n", dsm_out_n, ~dsm_out);
    check("mod_dsm_out_n", m_out_n, ~m_out);
`endif
  end

  task automatic main_seq();
    longint lsum;
    longint diff;
    int     k;
    int     hold;
    lsum = 0;
    for (int i = 0; i < N; i++) begin
      lut[i] = $rtoi(32768.0 + 32767.0 * $sin(2.0 * PI * real'(i) / real'(N)) + 0.5);
      lsum += longint'(lut[i]);
    end
    #1 rst_n = 1'b0;
    repeat (20) clock_cycle();
    @(negedge clk);
    rst_n     = 1'b1;
    first_run = 1'b1;
    repeat (DIV * (N + 2)) clock_cycle();
    first_run = 1'b0;
    n_chk++;
    diff = longint'(ones_cnt) * 65536 - longint'(DIV) * lsum;
    if (diff > 65536 || diff < -65536) begin
      n_fail++;
      $display("FAIL period_ones: got %0d expected %0d +/-1", ones_cnt, (longint'(DIV) * lsum) / 65536);
    end
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(50, 2500);
      repeat (k) clock_cycle();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      push_reset();
      #1;
      check("async_tick", tick, 0);
      check("async_sin", sin_out, 32768);
      check("async_dsm", dsm_out, 0);
      hold = $urandom_range(1, 5);
      repeat (hold) clock_cycle();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * DIV + $urandom_range(0, 150)) clock_cycle();
    end
  endtask

  task automatic mod_seq();
    int ones;
    @(negedge clk);
    din_m   = 16'h8000;
    rst_m_n = 1'b0;
    @(negedge clk);
    check("mod_reset", m_out, 0);
    rst_m_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mod_half", m_out, i % 2);
    end
    rst_m_n = 1'b0;
    din_m   = 16'h4000;
    @(negedge clk);
    rst_m_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mod_quarter", m_out, (i % 4) == 3);
    end
    rst_m_n = 1'b0;
    din_m   = 16'h0000;
    @(negedge clk);
    rst_m_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mod_zero", m_out, 0);
    end
    rst_m_n = 1'b0;
    din_m   = 16'hFFFF;
    @(negedge clk);
    rst_m_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (m_out === 1'b1) ones++;
    end
    check("mod_full_ones", ones, 65535);
  endtask

  initial begin
    fork
      main_seq();
      mod_seq();
    join
    repeat (2) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
